// File: rtl/soc_system_stepper_pkg.sv
// soc_system_stepper_pkg: shared register map, bit indices and channel FSM states
// for the stepper step/dir pulse generator.
package soc_system_stepper_pkg;
   localparam logic [1:0] REG_PERIOD = 2'd0;
   localparam logic [1:0] REG_STEPS  = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;
   localparam int CTRL_EN   = 0;
   localparam int CTRL_DIR  = 1;
   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} ch_state_t;
endpackage

// File: rtl/soc_system_stepper_pulse_ch.sv
// soc_system_stepper_pulse_ch: one stepper channel -- period timer, shadow/active
// period, remaining step count, run/drain FSM and its register slice.
module soc_system_stepper_pulse_ch
   import soc_system_stepper_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int PULSE_W    = 100,
   parameter int MIN_PERIOD = 2 * PULSE_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr,
   input  logic [1:0]  reg_sel,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        step,
   output logic        dir,
   output logic        done_pending
);
   logic [CNT_W-1:0] wval, per_clamp, shadow, active, timer, remaining;
   logic en, dir_cfg, busy, boundary, start, finish, pulse_end;
   ch_state_t state, state_nx;

   assign wval      = writedata[CNT_W-1:0];
   assign per_clamp = (wval < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : wval;
   assign boundary  = timer == active - 1'b1;
   assign pulse_end = timer >= CNT_W'(PULSE_W - 1);
   assign start     = wr && reg_sel == REG_STEPS && wval != '0 && en && state == IDLE;
   assign finish    = state == RUN && boundary && remaining == '0;

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nx;

   // Dropping en mid-move lets the pulse in flight complete but starts no new one.
   always_comb begin
      state_nx = state;
      if (state == IDLE)                      state_nx = start ? RUN : IDLE;
      else if (state == RUN && (finish || en)) state_nx = finish ? IDLE : RUN;
      else                                     state_nx = pulse_end ? IDLE : DRAIN;
   end

   always_comb begin
      busy = state != IDLE;
      step = busy && timer < CNT_W'(PULSE_W);
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         shadow       <= CNT_W'(MIN_PERIOD);
         active       <= CNT_W'(MIN_PERIOD);
         timer        <= '0;
         remaining    <= '0;
         en           <= 1'b0;
         dir_cfg      <= 1'b0;
         dir          <= 1'b0;
         done_pending <= 1'b0;
      end else begin
         if (wr && reg_sel == REG_PERIOD) shadow <= per_clamp;
         // A running channel only adopts a new period on a period boundary.
         if (wr && reg_sel == REG_PERIOD && !busy) active <= per_clamp;
         else if (start)                          active <= shadow;
         else if (state == RUN && boundary)       active <= shadow;
         timer <= start ? '0 : !busy ? timer : boundary ? '0 : timer + 1'b1;
         remaining <= start ? wval
                    : (state == RUN && timer == '0 && remaining != '0) ? remaining - 1'b1
                    : remaining;
         if (wr && reg_sel == REG_CTRL) begin
            en      <= writedata[CTRL_EN];
            dir_cfg <= writedata[CTRL_DIR];
         end
         if (start) dir <= dir_cfg;
         done_pending <= finish || (done_pending && !(wr && reg_sel == REG_STATUS && writedata[STAT_DONE]));
      end

   always_comb begin
      readdata = '0;
      readdata = reg_sel == REG_PERIOD ? 32'(shadow)
               : reg_sel == REG_STEPS  ? 32'(remaining)
               : reg_sel == REG_CTRL   ? {30'b0, dir_cfg, en}
               :                         {30'b0, done_pending, busy};
   end
endmodule

// File: rtl/soc_system_stepper_pulse_gen.sv
// soc_system_stepper_pulse_gen: Avalon-MM multi-channel stepper STEP/DIR pulse
// generator with a level completion interrupt.
module soc_system_stepper_pulse_gen
   import soc_system_stepper_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 32,
   parameter int PULSE_W    = 100,
   parameter int MIN_PERIOD = 2 * PULSE_W,
   localparam int AW        = $clog2(NUM_CH) + 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AW-1:0]     address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [NUM_CH-1:0] step,
   output logic [NUM_CH-1:0] dir,
   output logic              irq
);
   logic wr;
   logic [AW-1:0] ch_sel;
   logic [31:0] ch_rd [NUM_CH];
   logic [NUM_CH-1:0] done;

   assign wr     = chipselect && !write_n;
   assign ch_sel = address >> 2;

   genvar c;
   generate
      for (c = 0; c < NUM_CH; c++) begin : g_ch
         soc_system_stepper_pulse_ch #(
            .CNT_W(CNT_W), .PULSE_W(PULSE_W), .MIN_PERIOD(MIN_PERIOD)
         ) u_ch (
            .clk(clk),
            .reset(reset),
            .wr(wr && ch_sel == AW'(c)),
            .reg_sel(address[1:0]),
            .writedata(writedata),
            .readdata(ch_rd[c]),
            .step(step[c]),
            .dir(dir[c]),
            .done_pending(done[c])
         );
      end
   endgenerate

   // Channel indices with no instance fall through to zero.
   always_comb begin
      readdata = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (ch_sel == AW'(i)) readdata = ch_rd[i];
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) irq <= 1'b0;
      else       irq <= |done;
endmodule

// File: doc/soc_system_stepper_pulse_gen.md
Name: soc_system_stepper_pulse_gen

Overview:
- Multi-channel Avalon-MM stepper step/dir pulse generator; successor to the single 32-bit speed PIO register.
- Instead of exporting a raw speed word, the block generates timed STEP pulses itself: a programmed step count at a programmed period, per channel.
- Sits on the HPS lightweight bridge; STEP/DIR drive the stepper driver pins.
- A level IRQ signals move completion to Marlin firmware.

Parameters:
- NUM_CH, 4, number of independent stepper channels (1..8).
- CNT_W, 32, width of period timer and step counter (16..32).
- PULSE_W, 100, STEP high time in clk cycles.
- MIN_PERIOD, 2*PULSE_W, smallest accepted period; smaller writes are clamped up to this value.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  $clog2(NUM_CH)+2  [MSBs]=channel, [1:0]=register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational, zero wait states.
- step  out  NUM_CH  STEP pulses.
- dir  out  NUM_CH  direction per channel.
- irq  out  1  OR of all channels' done_pending bits.

Behaviour:
- Write occurs when chipselect && !write_n.
- Register map per channel:
  - 0 PERIOD (RW). Writes go to a shadow register; reads return the shadow.
  - 1 STEPS (W: start move; R: remaining steps).
  - 2 CTRL (RW). bit0 en, bit1 dir; other bits read 0.
  - 3 STATUS. bit0 busy (RO), bit1 done_pending (W1C); other bits 0.
- Unused bits read 0. Writedata above CNT_W is ignored.
- Reset: step=0, dir=0, irq=0, busy=0, done_pending=0, remaining=0, en=0, period shadow and active = MIN_PERIOD.
- PERIOD write: shadow <= max(writedata, MIN_PERIOD).
  - Idle channel: active period also updates in the same cycle.
  - Busy channel: active period takes the shadow at the next period boundary (timer==active-1).
  - A write landing exactly on a boundary cycle applies at the following boundary.
- Start: STEPS write with value N>0 while en=1 and busy=0.
  - Next cycle: busy=1, remaining=N, timer=0, dir output latched from CTRL.dir.
  - STEPS write ignored if busy=1, N=0, or en=0.
- Per-channel FSM:
  - IDLE -> RUN on start.
  - RUN:
    - timer increments each cycle and wraps at active-1.
    - step=1 while timer<PULSE_W and the current step is counted.
    - remaining decrements in the cycle timer==0 (step rising edge).
    - At timer==active-1 with remaining==0: RUN -> IDLE, busy=0, done_pending=1.
    - So the last pulse is followed by a full period before busy drops.
  - RUN with en cleared -> DRAIN.
  - DRAIN: finish the current pulse (step stays high until timer==PULSE_W), no further pulses, then IDLE.
    - remaining is preserved; done_pending is not set.
- Latency: first STEP rising edge is 1 cycle after the accepted STEPS write.
- Pulse spacing: consecutive rising edges are exactly active-period cycles apart.
- CTRL.dir writes while busy are stored but reach the dir pin only at the next start.
- Simultaneous done set and W1C clear on the same channel: set wins.
- irq is registered: asserts 1 cycle after done_pending sets and deasserts 1 cycle after the last pending bit clears.
- Reset mid-move: step drops asynchronously; all state returns to reset values.
- Address to a channel index >= NUM_CH: reads 0, writes ignored.

Decomposition:
- Shared package soc_system_stepper_pkg:
  - register offsets (REG_PERIOD=0, REG_STEPS=1, REG_CTRL=2, REG_STATUS=3);
  - CTRL/STATUS bit indices;
  - channel FSM state enum (IDLE, RUN, DRAIN).
- One sub-module, soc_system_stepper_pulse_ch:
  - holds timer, shadow/active period, remaining count, FSM, step/dir for one channel;
  - instantiated NUM_CH times.
- Top level holds address decode, read mux, and irq OR/register.

Test Plan (NUM_CH=2, PULSE_W=4, MIN_PERIOD=8, CNT_W=16):
- CTRL0=1, PERIOD0=10, STEPS0=3 -> step[0] rises at t+1, t+11, t+21, each 4 cycles high; busy drops and irq rises at t+31 (registered, one cycle later); STATUS0 reads 0b10.
- PERIOD0=3 -> reads back 8; 2 steps give rising edges 8 cycles apart.
- During 5-step move at period 10, write PERIOD0=20 after first pulse -> spacing 10 until the next boundary, then 20; no truncated pulse.
- Clear CTRL0.en at timer=2 of step 2 of 5 -> step stays high through timer=3, then no more pulses; remaining reads 3; irq stays 0.
- Both channels finish same cycle; W1C ch0 only -> irq stays 1; W1C ch1 -> irq drops one cycle later; W1C coinciding with a new done -> bit stays 1.
- Assert reset with step high mid-move -> step=0 immediately; all registers read reset values; STEPS write while busy or with en=0 is ignored.
